// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, funct codes,
// FSM state encoding, ALU control codes and output select values.
package mc_ctrl_pkg;

    // Primary opcodes (Ins[31:26])
    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] XORI   = 6'h0E;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    // R-form funct codes (Ins[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // Next-PC select
    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JUMP = 2'd2;
    localparam logic [1:0] PC_REG  = 2'd3;

    // Write-register select
    localparam logic [1:0] WSEL_RT = 2'd0;
    localparam logic [1:0] WSEL_RD = 2'd1;
    localparam logic [1:0] WSEL_RA = 2'd2;

    localparam int unsigned WCNT_W = 8;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    // Destination register select for the write-back of a given opcode
    function automatic logic [1:0] wsel_of(input logic [5:0] op);
        case (op)
            R_FORM:  return WSEL_RD;
            JAL:     return WSEL_RA;
            default: return WSEL_RT;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_dec: combinational instruction decode into ALU control, operand select,
// immediate extension mode and opcode legality.
module mc_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       ext_zero,
    output logic       alu_src_imm,
    output logic       op_valid
);

    // Opcode/funct to datapath controls
    always_comb begin
        alu_ctl     = ALU_ADD;
        ext_zero    = 1'b0;
        alu_src_imm = 1'b0;
        op_valid    = 1'b0;
        case (op)
            R_FORM: begin
                op_valid = 1'b1;
                case (funct)
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_XOR:  alu_ctl = ALU_XOR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            J, JAL: op_valid = 1'b1;
            BEQ, BNE: begin
                op_valid = 1'b1;
                alu_ctl  = ALU_SUB;
            end
            ADDI, LW, SW: begin
                op_valid    = 1'b1;
                alu_src_imm = 1'b1;
            end
            ANDI: begin
                op_valid    = 1'b1;
                alu_src_imm = 1'b1;
                ext_zero    = 1'b1;
                alu_ctl     = ALU_AND;
            end
            ORI: begin
                op_valid    = 1'b1;
                alu_src_imm = 1'b1;
                ext_zero    = 1'b1;
                alu_ctl     = ALU_OR;
            end
            XORI: begin
                op_valid    = 1'b1;
                alu_src_imm = 1'b1;
                ext_zero    = 1'b1;
                alu_ctl     = ALU_XOR;
            end
            default: op_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control FSM with memory wait timeout.
// Optional MC_CTRL_INSTRET_EN adds a retired-instruction counter output.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        mem_ifetch,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_wsel,
    output logic        alu_src_imm,
    output logic        ext_zero,
    output logic [3:0]  alu_ctl,
    output logic [2:0]  state,
`ifdef MC_CTRL_INSTRET_EN
    output logic [31:0] instret,
`endif
    output logic        err
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       op_valid;
    logic       timeout;
    logic       unused_ins_bits;
    logic [1:0] wsel;
    logic [4:0] dest;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;

    assign op              = Ins[31:26];
    assign rt              = Ins[20:16];
    assign rd              = Ins[15:11];
    assign funct           = Ins[5:0];
    assign unused_ins_bits = ^{Ins[25:21], Ins[10:6]};

    mc_dec u_dec (
        .op          (op),
        .funct       (funct),
        .alu_ctl     (alu_ctl),
        .ext_zero    (ext_zero),
        .alu_src_imm (alu_src_imm),
        .op_valid    (op_valid)
    );

    // Last tolerated wait cycle: a miss now means the limit is reached
    assign timeout = (wcnt_q == WCNT_W'(WAIT_MAX - 1));

    // Destination index selected for write-back
    assign wsel = wsel_of(op);
    always_comb begin
        dest = rt;
        case (wsel)
            WSEL_RD: dest = rd;
            WSEL_RA: dest = 5'd31;
            default: dest = rt;
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state and strobes; reset forces every strobe low immediately
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_ifetch = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = PC_INC;
        reg_wsel   = WSEL_RT;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PC_INC;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (!op_valid) begin
                    state_d = S_ERR;
                end else if (op == J) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    state_d = S_FETCH;
                end else if (op == JAL) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    BEQ, BNE: begin
                        if ((op == BEQ) == zero) begin
                            pc_we  = 1'b1;
                            pc_src = PC_BR;
                        end
                        state_d = S_FETCH;
                    end
                    R_FORM: begin
                        if (funct == FN_JR) begin
                            pc_we   = 1'b1;
                            pc_src  = PC_REG;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    LW, SW:  state_d = S_MEM;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_wr  = (op == SW);
                if (mem_ack) begin
                    state_d = (op == LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                reg_wsel = wsel;
                reg_we   = (dest != 5'd0);
                state_d  = S_FETCH;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
        if (RST) begin
            mem_req    = 1'b0;
            mem_wr     = 1'b0;
            mem_ifetch = 1'b0;
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            pc_src     = PC_INC;
            reg_wsel   = WSEL_RT;
        end
    end

    // Wait counter: counts unanswered requests, clears on any state change
    always_comb begin
        wcnt_d = wcnt_q;
        if (state_d != state_q) begin
            wcnt_d = '0;
        end else if (mem_req && !mem_ack) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
    end

    assign state = state_q;
    assign err   = (state_q == S_ERR);

`ifdef MC_CTRL_INSTRET_EN
    logic [31:0] instret_q;

    // Retire on the last state of each instruction returning to FETCH
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instret_q <= '0;
        end else if (state_q != S_FETCH && state_q != S_ERR && state_d == S_FETCH) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: cycle-by-cycle vector table plus
// hand-written reset, timeout, illegal-opcode and counter sequences.
module tb_mc_ctrl;

    logic        CLK;
    logic        RST;
    logic [31:0] Ins;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_wr, mem_ifetch, pc_we, ir_we, reg_we;
    logic [1:0]  pc_src, reg_wsel;
    logic        alu_src_imm, ext_zero;
    logic [3:0]  alu_ctl;
    logic [2:0]  state;
    logic        err;
`ifdef MC_CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad   = 0;

    mc_ctrl #(.WAIT_MAX(15)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Ins         (Ins),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_ifetch  (mem_ifetch),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .reg_we      (reg_we),
        .pc_src      (pc_src),
        .reg_wsel    (reg_wsel),
        .alu_src_imm (alu_src_imm),
        .ext_zero    (ext_zero),
        .alu_ctl     (alu_ctl),
        .state       (state),
`ifdef MC_CTRL_INSTRET_EN
        .instret     (instret),
`endif
        .err         (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {mem_req, mem_wr, mem_ifetch, pc_we, ir_we, reg_we, pc_src, reg_wsel}
    logic [9:0] outs;
    assign outs = {mem_req, mem_wr, mem_ifetch, pc_we, ir_we, reg_we, pc_src, reg_wsel};

    localparam logic [9:0] O_IDLE  = 10'b000000_00_00;
    localparam logic [9:0] O_FWAIT = 10'b101000_00_00;
    localparam logic [9:0] O_FACK  = 10'b101110_00_00;
    localparam logic [9:0] O_BR    = 10'b000100_01_00;
    localparam logic [9:0] O_JMP   = 10'b000100_10_00;
    localparam logic [9:0] O_JR    = 10'b000100_11_00;
    localparam logic [9:0] O_MRD   = 10'b100000_00_00;
    localparam logic [9:0] O_MWR   = 10'b110000_00_00;
    localparam logic [9:0] O_WBRT  = 10'b000001_00_00;
    localparam logic [9:0] O_WBRD  = 10'b000001_00_01;
    localparam logic [9:0] O_WBRA  = 10'b000001_00_10;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd5;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic        ack;
        logic [2:0]  st;
        logic [9:0]  o;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic add(input logic [31:0] ins, input logic z, input logic ack,
                       input logic [2:0] st, input logic [9:0] o);
        vec_t v;
        v.ins = ins; v.z = z; v.ack = ack; v.st = st; v.o = o;
        vt.push_back(v);
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle
    task automatic step(input logic [31:0] ins, input logic z, input logic ack,
                        input logic [2:0] st, input logic [9:0] o, input string tag);
        Ins = ins; zero = z; mem_ack = ack;
        @(negedge CLK);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " strobes"}, 32'(outs), 32'(o));
        check({tag, " err"}, 32'(err), 32'(st == X));
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; mem_ack = 1'b0; zero = 1'b0;
        @(posedge CLK); #1;
        check("rst state", 32'(state), 32'(F));
        check("rst strobes", 32'(outs), 32'(O_IDLE));
        RST = 1'b0;
    endtask

    logic [31:0] i_add, i_beq, i_lw, i_sw, i_ori0, i_jal, i_j, i_jr, i_addi, i_bad;
    logic [31:0] d_ins[10];
    logic [5:0]  d_exp[10];

    initial begin
        i_add  = r_ins(5'd9, 5'd10, 5'd8, 6'h20);
        i_beq  = i_ins(6'h04, 5'd1, 5'd2, 16'h0010);
        i_lw   = i_ins(6'h23, 5'd3, 5'd5, 16'h0004);
        i_sw   = i_ins(6'h2B, 5'd3, 5'd5, 16'h0004);
        i_ori0 = i_ins(6'h0D, 5'd4, 5'd0, 16'h00FF);
        i_jal  = {6'h03, 26'h0000100};
        i_j    = {6'h02, 26'h0000040};
        i_jr   = r_ins(5'd31, 5'd0, 5'd0, 6'h08);
        i_addi = i_ins(6'h08, 5'd1, 5'd7, 16'hFFFF);
        i_bad  = {6'h3F, 26'h0};

        // Decode expectations {alu_ctl, ext_zero, alu_src_imm}
        d_ins[0] = i_add;                               d_exp[0] = {4'd0, 1'b0, 1'b0};
        d_ins[1] = r_ins(5'd1, 5'd2, 5'd3, 6'h22);      d_exp[1] = {4'd1, 1'b0, 1'b0};
        d_ins[2] = r_ins(5'd1, 5'd2, 5'd3, 6'h2A);      d_exp[2] = {4'd5, 1'b0, 1'b0};
        d_ins[3] = i_beq;                               d_exp[3] = {4'd1, 1'b0, 1'b0};
        d_ins[4] = i_ori0;                              d_exp[4] = {4'd3, 1'b1, 1'b1};
        d_ins[5] = i_ins(6'h0C, 5'd1, 5'd2, 16'h1);     d_exp[5] = {4'd2, 1'b1, 1'b1};
        d_ins[6] = i_ins(6'h0E, 5'd1, 5'd2, 16'h1);     d_exp[6] = {4'd4, 1'b1, 1'b1};
        d_ins[7] = i_addi;                              d_exp[7] = {4'd0, 1'b0, 1'b1};
        d_ins[8] = i_lw;                                d_exp[8] = {4'd0, 1'b0, 1'b1};
        d_ins[9] = i_sw;                                d_exp[9] = {4'd0, 1'b0, 1'b1};

        // ADD: reg_we with rd select in the fourth cycle
        add(i_add, 0, 1, F, O_FACK); add(i_add, 0, 0, D, O_IDLE);
        add(i_add, 0, 0, E, O_IDLE); add(i_add, 0, 0, W, O_WBRD);
        // BEQ taken then not taken
        add(i_beq, 0, 1, F, O_FACK); add(i_beq, 1, 0, D, O_IDLE); add(i_beq, 1, 0, E, O_BR);
        add(i_beq, 0, 1, F, O_FACK); add(i_beq, 0, 0, D, O_IDLE); add(i_beq, 0, 0, E, O_IDLE);
        // LW with three wait cycles in MEM
        add(i_lw, 0, 1, F, O_FACK); add(i_lw, 0, 0, D, O_IDLE); add(i_lw, 0, 0, E, O_IDLE);
        add(i_lw, 0, 0, M, O_MRD);  add(i_lw, 0, 0, M, O_MRD);  add(i_lw, 0, 0, M, O_MRD);
        add(i_lw, 0, 1, M, O_MRD);  add(i_lw, 0, 0, W, O_WBRT);
        // SW straight back to FETCH
        add(i_sw, 0, 1, F, O_FACK); add(i_sw, 0, 0, D, O_IDLE); add(i_sw, 0, 0, E, O_IDLE);
        add(i_sw, 0, 1, M, O_MWR);
        // ORI to r0: write-back suppressed
        add(i_ori0, 0, 1, F, O_FACK); add(i_ori0, 0, 0, D, O_IDLE);
        add(i_ori0, 0, 0, E, O_IDLE); add(i_ori0, 0, 0, W, O_IDLE);
        // JAL, J, JR
        add(i_jal, 0, 1, F, O_FACK); add(i_jal, 0, 0, D, O_JMP); add(i_jal, 0, 0, W, O_WBRA);
        add(i_j, 0, 1, F, O_FACK);   add(i_j, 0, 0, D, O_JMP);
        add(i_jr, 0, 1, F, O_FACK);  add(i_jr, 0, 0, D, O_IDLE); add(i_jr, 0, 0, E, O_JR);
        // ADDI with fetch wait and stray acks outside a request
        add(i_addi, 0, 0, F, O_FWAIT); add(i_addi, 0, 0, F, O_FWAIT);
        add(i_addi, 0, 1, F, O_FACK);  add(i_addi, 0, 1, D, O_IDLE);
        add(i_addi, 0, 1, E, O_IDLE);  add(i_addi, 0, 1, W, O_WBRT);
        add(i_add, 0, 0, F, O_FWAIT);

        // Reset state and decode checks while held in reset
        RST = 1'b1; Ins = i_add; zero = 1'b0; mem_ack = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("reset state", 32'(state), 32'(F));
        check("reset strobes", 32'(outs), 32'(O_IDLE));
        check("reset err", 32'(err), 32'd0);
`ifdef MC_CTRL_INSTRET_EN
        check("reset instret", instret, 32'd0);
`endif
        for (int k = 0; k < 10; k++) begin
            Ins = d_ins[k];
            #1;
            check($sformatf("decode%0d", k), 32'({alu_ctl, ext_zero, alu_src_imm}), 32'(d_exp[k]));
        end
        mem_ack = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int k = 0; k < vt.size(); k++) begin
            step(vt[k].ins, vt[k].z, vt[k].ack, vt[k].st, vt[k].o, $sformatf("vec%0d", k));
        end

        // Fetch timeout: fifteen unanswered cycles then sticky ERR
        do_reset();
        for (int k = 1; k <= 15; k++) step(i_add, 0, 0, F, O_FWAIT, $sformatf("to_wait%0d", k));
        for (int k = 0; k < 3; k++) step(i_add, 0, 1, X, O_IDLE, $sformatf("to_err%0d", k));

        // Ack on the fifteenth cycle wins
        do_reset();
        for (int k = 1; k <= 14; k++) step(i_add, 0, 0, F, O_FWAIT, $sformatf("ack15_wait%0d", k));
        step(i_add, 0, 1, F, O_FACK, "ack15_fetch");
        step(i_add, 0, 0, D, O_IDLE, "ack15_decode");
        step(i_add, 0, 0, E, O_IDLE, "ack15_exec");
        step(i_add, 0, 0, W, O_WBRD, "ack15_wb");

        // Reset in the middle of an SW memory wait
        step(i_sw, 0, 1, F, O_FACK, "rsw_fetch");
        step(i_sw, 0, 0, D, O_IDLE, "rsw_decode");
        step(i_sw, 0, 0, E, O_IDLE, "rsw_exec");
        step(i_sw, 0, 0, M, O_MWR, "rsw_mem");
        RST = 1'b1;
        #1;
        check("rsw mem_req", 32'(mem_req), 32'd0);
        check("rsw mem_wr", 32'(mem_wr), 32'd0);
        check("rsw state", 32'(state), 32'(F));
`ifdef MC_CTRL_INSTRET_EN
        check("rsw instret", instret, 32'd0);
`endif
        @(posedge CLK); #1;
        RST = 1'b0;

        // Three complete instructions after reset
        step(i_add, 0, 1, F, O_FACK, "n3_add_f");
        step(i_add, 0, 0, D, O_IDLE, "n3_add_d");
        step(i_add, 0, 0, E, O_IDLE, "n3_add_e");
        step(i_add, 0, 0, W, O_WBRD, "n3_add_w");
        step(i_j, 0, 1, F, O_FACK, "n3_j_f");
        step(i_j, 0, 0, D, O_JMP, "n3_j_d");
        step(i_sw, 0, 1, F, O_FACK, "n3_sw_f");
        step(i_sw, 0, 0, D, O_IDLE, "n3_sw_d");
        step(i_sw, 0, 0, E, O_IDLE, "n3_sw_e");
        step(i_sw, 0, 1, M, O_MWR, "n3_sw_m");
`ifdef MC_CTRL_INSTRET_EN
        check("instret after 3", instret, 32'd3);
`endif

        // Illegal opcode lands in sticky ERR
        step(i_bad, 0, 1, F, O_FACK, "bad_fetch");
        step(i_bad, 0, 0, D, O_IDLE, "bad_decode");
        step(i_bad, 0, 1, X, O_IDLE, "bad_err0");
        step(i_add, 1, 1, X, O_IDLE, "bad_err1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
